// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite scheduler and its sprite table.
package sprite_pkg;

   localparam int CORD_W  = 10;
   localparam int SCALE_W = 8;
   localparam int IMG_W   = 4;
   localparam int DEPTH   = 16;
   localparam int H_RES   = 800;
   localparam int V_RES   = 480;

   // valid must stay the first (most significant) field: the table stores it apart from the rest
   typedef struct packed {
      logic               valid;
      logic [CORD_W-1:0]  x;
      logic [CORD_W-1:0]  y;
      logic [SCALE_W-1:0] scale;
      logic [IMG_W-1:0]   img;
   } sprite_entry_t;

   typedef enum logic [2:0] {IDLE, FETCH, CLEAR, RUN, NEXT, DONE} sched_state_t;

   function automatic logic entry_active(input sprite_entry_t e);
      return e.valid && (e.scale != {SCALE_W{1'b0}});
   endfunction

endpackage

// File: rtl/sprite_table.sv
// Sprite list register file: synchronous write, combinational read, valid bits cleared by reset.
module sprite_table
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES = DEPTH,
   localparam int IW = $clog2(NUM_SPRITES)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [IW-1:0] wr_idx,
   input  sprite_entry_t wr_entry,
   input  logic [IW-1:0] rd_idx,
   output sprite_entry_t rd_entry
);

   localparam int DW = $bits(sprite_entry_t) - 1;

   logic [NUM_SPRITES-1:0] valid;
   logic [DW-1:0]          mem [NUM_SPRITES];

   // valid bits: the only table state that reset must clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= {NUM_SPRITES{1'b0}};
      end else if (we) begin
         valid[wr_idx] <= wr_entry.valid;
      end
   end

   // payload fields, never reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_idx] <= wr_entry[DW-1:0];
      end
   end

   // combinational read port
   always_comb begin
      rd_entry = {valid[rd_idx], mem[rd_idx]};
   end

endmodule

// File: rtl/sprite_scheduler.sv
// Walks the sprite table once per frame, driving one sprite renderer through each active entry.
module sprite_scheduler
   import sprite_pkg::*;
#(
   parameter int CORDW       = CORD_W,
   parameter int NUM_SPRITES = DEPTH,
   parameter int IMGW        = IMG_W,
   parameter int SCALEW      = SCALE_W
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           tbl_we,
   input  logic [$clog2(NUM_SPRITES)-1:0] tbl_idx,
   input  logic                           tbl_valid,
   input  logic [CORDW-1:0]               tbl_x,
   input  logic [CORDW-1:0]               tbl_y,
   input  logic [SCALEW-1:0]              tbl_scale,
   input  logic [IMGW-1:0]                tbl_img,
   input  logic                           frame_start,
   input  logic                           render_finished,
   output logic                           render_rst,
   output logic                           render_en,
   output logic [CORDW-1:0]               spr_x,
   output logic [CORDW-1:0]               spr_y,
   output logic [SCALEW-1:0]              spr_scale,
   output logic [IMGW-1:0]                spr_img,
   output logic                           busy,
   output logic                           frame_done,
   output logic                           overrun
);

   localparam int IW = $clog2(NUM_SPRITES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);

   sched_state_t  state, next_state;
   logic [IW-1:0] idx;
   logic          idx_inc;
   logic          latch;
   logic          run_first;
   sprite_entry_t wr_entry;
   sprite_entry_t rd_entry;

   assign wr_entry = '{valid: tbl_valid, x: tbl_x, y: tbl_y, scale: tbl_scale, img: tbl_img};

   sprite_table #(.NUM_SPRITES(NUM_SPRITES)) u_table (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (tbl_we),
      .wr_idx   (tbl_idx),
      .wr_entry (wr_entry),
      .rd_idx   (idx),
      .rd_entry (rd_entry)
   );

   // next-state decode
   always_comb begin
      next_state = state;
      idx_inc    = 1'b0;
      latch      = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) next_state = FETCH;
            else             next_state = IDLE;
         end
         FETCH: begin
            if (entry_active(rd_entry)) begin
               latch      = 1'b1;
               next_state = CLEAR;
            end else if (idx == LAST_IDX) begin
               next_state = DONE;
            end else begin
               idx_inc    = 1'b1;
               next_state = FETCH;
            end
         end
         CLEAR: next_state = RUN;
         RUN: begin
            // the finished flag may still be high from the previous sprite on the first RUN cycle
            if (!run_first && render_finished) next_state = NEXT;
            else                               next_state = RUN;
         end
         NEXT: begin
            if (idx == LAST_IDX) begin
               next_state = DONE;
            end else begin
               idx_inc    = 1'b1;
               next_state = FETCH;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // state, index counter and registered outputs (outputs follow the state being entered)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= {IW{1'b0}};
         run_first  <= 1'b0;
         render_rst <= 1'b0;
         render_en  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         spr_x      <= {CORDW{1'b0}};
         spr_y      <= {CORDW{1'b0}};
         spr_scale  <= {SCALEW{1'b0}};
         spr_img    <= {IMGW{1'b0}};
      end else begin
         state      <= next_state;
         if (state == IDLE)  idx <= {IW{1'b0}};
         else if (idx_inc)   idx <= idx + IW'(1'b1);
         run_first  <= (next_state == RUN) && (state != RUN);
         render_rst <= (next_state == CLEAR);
         render_en  <= (next_state == RUN);
         busy       <= (next_state != IDLE);
         frame_done <= (next_state == DONE);
         overrun    <= frame_start && (state != IDLE);
         if (latch) begin
            spr_x     <= rd_entry.x;
            spr_y     <= rd_entry.y;
            spr_scale <= rd_entry.scale;
            spr_img   <= rd_entry.img;
         end
      end
   end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler with a behavioural renderer and frame model.
module tb_sprite_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tbl_we = 1'b0;
   logic [3:0] tbl_idx = 4'd0;
   logic       tbl_valid = 1'b0;
   logic [9:0] tbl_x = 10'd0;
   logic [9:0] tbl_y = 10'd0;
   logic [7:0] tbl_scale = 8'd0;
   logic [3:0] tbl_img = 4'd0;
   logic       frame_start = 1'b0;
   logic       render_finished = 1'b0;
   logic       render_rst, render_en, busy, frame_done, overrun;
   logic [9:0] spr_x, spr_y;
   logic [7:0] spr_scale;
   logic [3:0] spr_img;

   sprite_scheduler dut (
      .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_valid(tbl_valid),
      .tbl_x(tbl_x), .tbl_y(tbl_y), .tbl_scale(tbl_scale), .tbl_img(tbl_img),
      .frame_start(frame_start), .render_finished(render_finished),
      .render_rst(render_rst), .render_en(render_en), .spr_x(spr_x), .spr_y(spr_y),
      .spr_scale(spr_scale), .spr_img(spr_img), .busy(busy), .frame_done(frame_done),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Renderer model: raises finished so the scheduler sees it after run_len enabled cycles.
   // The flag clears one cycle after render_rst, so it is still stale on the first RUN cycle.
   int   run_len = 4;
   int   rcnt = 0;
   logic rst_d = 1'b0;
   always @(posedge clk) begin
      rst_d <= render_rst;
      if (rst_d) begin
         rcnt <= 1;
         render_finished <= (1 >= run_len - 1);
      end else if (render_en) begin
         rcnt <= rcnt + 1;
         if (rcnt + 1 >= run_len - 1) render_finished <= 1'b1;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack(input int x, input int y, input int s, input int img);
      return {x[9:0], y[9:0], s[7:0], img[3:0]};
   endfunction

   // table model
   int m_v[16], m_x[16], m_y[16], m_s[16], m_i[16];
   logic [31:0] exp_q[$];
   logic [31:0] cap_q[$];

   task automatic write_entry(input int i, input int v, input int x, input int y, input int s, input int img);
      @(negedge clk);
      tbl_idx = i[3:0]; tbl_valid = v[0]; tbl_x = x[9:0]; tbl_y = y[9:0];
      tbl_scale = s[7:0]; tbl_img = img[3:0]; tbl_we = 1'b1;
      @(negedge clk);
      tbl_we = 1'b0;
      m_v[i] = v; m_x[i] = x; m_y[i] = y; m_s[i] = s; m_i[i] = img;
   endtask

   task automatic clear_table();
      for (int i = 0; i < 16; i++) write_entry(i, 0, 0, 0, 0, 0);
   endtask

   task automatic build_expect(output int elat);
      exp_q.delete();
      elat = 1;
      for (int i = 0; i < 16; i++) begin
         if (m_v[i] != 0 && m_s[i] != 0) begin
            exp_q.push_back(pack(m_x[i], m_y[i], m_s[i], m_i[i]));
            elat += 3 + run_len;
         end else begin
            elat += 1;
         end
      end
   endtask

   // frame run knobs and observations
   int inject_at = -1, write_at = -1, reset_at = -1;
   int w_x = 0;
   int lat, nen, nov, busy_low, busy_after, extra_done, spr_change, both_hi, en_pre;

   task automatic run_frame();
      cap_q.delete();
      nen = 0; nov = 0; busy_low = 0; busy_after = 0; extra_done = 0;
      spr_change = 0; both_hi = 0; en_pre = 0;
      @(negedge clk); frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
      lat = 1;
      while (lat < 5000) begin
         if (render_rst) cap_q.push_back({spr_x, spr_y, spr_scale, spr_img});
         else if (cap_q.size() > 0 && {spr_x, spr_y, spr_scale, spr_img} != cap_q[$]) spr_change++;
         if (render_en) nen++;
         if (render_rst && render_en) both_hi++;
         if (!busy) busy_low++;
         if (overrun) nov++;
         if (lat == inject_at) frame_start = 1'b1;
         if (lat == write_at) begin
            tbl_idx = 4'd0; tbl_x = w_x[9:0]; tbl_we = 1'b1;
         end
         if (lat == reset_at) begin
            en_pre = int'(render_en);
            rst_n = 1'b0;
            #1;
            check("rst_async_en", int'(render_en), 0);
            check("rst_async_busy", int'(busy), 0);
            check("rst_async_spr", int'({spr_x, spr_y, spr_scale, spr_img}), 0);
            lat = -1;
            break;
         end
         if (frame_done) break;
         @(negedge clk);
         frame_start = 1'b0; tbl_we = 1'b0;
         lat++;
      end
      if (lat != -1) begin
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            frame_start = 1'b0; tbl_we = 1'b0;
            if (frame_done) extra_done++;
            if (overrun) nov++;
            if (busy) busy_after++;
         end
      end
      inject_at = -1; write_at = -1; reset_at = -1;
   endtask

   typedef struct {
      int idx; int valid; int x; int y; int scale; int img; int run;
      int exp_nrst; int exp_lat;
   } vec_t;
   vec_t vecs[5];

   int elat;

   initial begin
      vecs[0] = '{3, 1, 100, 50, 16, 2, 256, 1, 275};
      vecs[1] = '{0, 1, 10, 10, 0, 1, 4, 0, 17};
      vecs[2] = '{15, 0, 20, 20, 5, 1, 4, 0, 17};
      vecs[3] = '{15, 1, 1023, 0, 255, 15, 2, 1, 21};
      vecs[4] = '{7, 1, 0, 479, 1, 0, 5, 1, 24};
      for (int i = 0; i < 16; i++) begin
         m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; m_s[i] = 0; m_i[i] = 0;
      end

      repeat (3) @(negedge clk);
      check("reset_outputs", int'({render_rst, render_en, busy, frame_done, overrun,
                                   spr_x, spr_y, spr_scale, spr_img} != 0), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // empty table straight out of reset
      run_frame();
      check("empty_lat", lat, 17);
      check("empty_rst", cap_q.size(), 0);
      check("empty_en", nen, 0);
      check("empty_busy_low", busy_low, 0);
      check("empty_busy_after", busy_after, 0);

      // single-entry vectors
      for (int k = 0; k < 5; k++) begin
         clear_table();
         write_entry(vecs[k].idx, vecs[k].valid, vecs[k].x, vecs[k].y, vecs[k].scale, vecs[k].img);
         run_len = vecs[k].run;
         run_frame();
         check($sformatf("vec%0d_lat", k), lat, vecs[k].exp_lat);
         check($sformatf("vec%0d_nrst", k), cap_q.size(), vecs[k].exp_nrst);
         check($sformatf("vec%0d_nen", k), nen, vecs[k].exp_nrst * vecs[k].run);
         check($sformatf("vec%0d_done_once", k), extra_done, 0);
         check($sformatf("vec%0d_busy", k), busy_low + busy_after, 0);
         if (cap_q.size() > 0)
            check($sformatf("vec%0d_spr", k), int'(cap_q[0]),
                  int'(pack(vecs[k].x, vecs[k].y, vecs[k].scale, vecs[k].img)));
      end

      // entries 0, 5, 15 rendered in order; 7 has zero scale
      clear_table();
      write_entry(0, 1, 10, 1, 1, 1);
      write_entry(5, 1, 50, 2, 2, 2);
      write_entry(7, 1, 70, 3, 0, 3);
      write_entry(15, 1, 150, 4, 3, 4);
      run_len = 3;
      run_frame();
      check("multi_nrst", cap_q.size(), 3);
      check("multi_lat", lat, 32);
      check("multi_nen", nen, 9);
      check("multi_overlap", both_hi, 0);
      if (cap_q.size() == 3) begin
         check("multi_order0", int'(cap_q[0][31:22]), 10);
         check("multi_order1", int'(cap_q[1][31:22]), 50);
         check("multi_order2", int'(cap_q[2][31:22]), 150);
      end

      // frame_start during RUN
      clear_table();
      write_entry(3, 1, 30, 30, 8, 1);
      run_len = 10;
      inject_at = 8;
      run_frame();
      check("ovr_run_count", nov, 1);
      check("ovr_run_lat", lat, 29);
      check("ovr_run_single_done", extra_done, 0);

      // frame_start in the DONE cycle is not queued
      clear_table();
      inject_at = 17;
      run_frame();
      check("ovr_done_count", nov, 1);
      check("ovr_done_lat", lat, 17);
      check("ovr_done_not_queued", extra_done + busy_after, 0);

      // table write to the active entry during RUN
      clear_table();
      write_entry(0, 1, 100, 50, 16, 2);
      run_len = 20;
      write_at = 5; w_x = 200;
      run_frame();
      m_x[0] = 200;
      check("inflight_latched_x", (cap_q.size() > 0) ? int'(cap_q[0][31:22]) : -1, 100);
      check("inflight_stable", spr_change, 0);
      check("inflight_end_x", int'(spr_x), 100);
      run_frame();
      check("next_frame_x", (cap_q.size() > 0) ? int'(cap_q[0][31:22]) : -1, 200);

      // reset in the middle of entry 2's RUN
      clear_table();
      write_entry(0, 1, 11, 1, 1, 1);
      write_entry(1, 1, 22, 2, 1, 2);
      write_entry(2, 1, 33, 3, 1, 3);
      run_len = 10;
      reset_at = 32;
      run_frame();
      check("rst_was_running", en_pre, 1);
      check("rst_reached_entry2", cap_q.size(), 3);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) m_v[i] = 0;
      @(negedge clk);
      check("rst_no_done", int'(frame_done), 0);
      run_frame();
      check("rst_table_invalid", cap_q.size(), 0);
      check("rst_lat", lat, 17);

      // randomized tables against the frame model
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < 16; i++)
            write_entry(i, ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1023),
                        $urandom_range(0, 1023),
                        ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
                        $urandom_range(0, 15));
         run_len = $urandom_range(2, 12);
         build_expect(elat);
         run_frame();
         check($sformatf("rnd%0d_lat", f), lat, elat);
         check($sformatf("rnd%0d_nrst", f), cap_q.size(), exp_q.size());
         check($sformatf("rnd%0d_nen", f), nen, exp_q.size() * run_len);
         for (int j = 0; j < exp_q.size() && j < cap_q.size(); j++)
            check($sformatf("rnd%0d_spr%0d", f, j), int'(cap_q[j]), int'(exp_q[j]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
